// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared types and helpers for the segmented add/sub pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        ADC = 2'b10,
        SBB = 2'b11
    } addsub_op_e;

    typedef struct packed {
        logic cout;
        logic ovfl;
        logic zero;
        logic neg;
    } addsub_flags_t;

    localparam int C_MAX_WIDTH = 64;

    // Signed limit of a width-bit word, right-aligned in a C_MAX_WIDTH vector.
    function automatic logic [C_MAX_WIDTH-1:0] signed_limit(input int width, input logic want_min);
        logic [C_MAX_WIDTH-1:0] msb_only;
        msb_only            = '0;
        msb_only[width-1]   = 1'b1;
        return want_min ? msb_only : (msb_only - 1'b1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_seg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_seg
//  Description : Combinational SEG-bit adder slice with carry-in/out,
//                carry into its top bit and a slice-zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           cmsb,
    output logic           seg_zero
);

    logic [SEG:0] w_total;

    assign w_total  = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, cin};
    assign sum      = w_total[SEG-1:0];
    assign cout     = w_total[SEG];
    // Carry into the top bit is recovered from that bit's sum and operands.
    assign cmsb     = a_seg[SEG-1] ^ b_seg[SEG-1] ^ w_total[SEG-1];
    assign seg_zero = ~|w_total[SEG-1:0];

endmodule
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pipe
//  Description : Segment-pipelined two's-complement add/sub (ADD/SUB/ADC/SBB)
//                with valid/ready on both sides, one stage per SEG bits.
//                Define ADDSUB_PIPE_SAT_EN for signed saturation on overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);

    localparam int STAGES = WIDTH / SEG;

    addsub_op_e       w_op;
    logic             w_stall;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Per-stage inputs: operands, partial sum, carry, valid, running zero.
    logic [WIDTH-1:0] w_a    [STAGES];
    logic [WIDTH-1:0] w_bx   [STAGES];
    logic [WIDTH-1:0] w_s    [STAGES];
    logic             w_c    [STAGES];
    logic             w_v    [STAGES];
    logic             w_z    [STAGES];
    // Per-stage results.
    logic [SEG-1:0]   w_sum  [STAGES];
    logic [WIDTH-1:0] w_s_nx [STAGES];
    logic             w_co   [STAGES];
    logic             w_cm   [STAGES];
    logic             w_sz   [STAGES];

    logic             r_vout;
    logic [WIDTH-1:0] r_result;
    addsub_flags_t    r_flags;

    logic [WIDTH-1:0] w_res_raw;
    logic [WIDTH-1:0] w_res_fin;
    logic             w_ovfl_fin;
    logic             w_zero_acc;
    logic             w_zero_fin;

    assign w_op     = addsub_op_e'(op);
    assign w_stall  = r_vout && !out_ready;
    assign in_ready = !rst && !w_stall;
    assign w_b_eff  = (w_op == SUB || w_op == SBB) ? ~b : b;

    always_comb begin
        w_c0 = 1'b0;
        case (w_op)
            ADD:      w_c0 = 1'b0;
            SUB:      w_c0 = 1'b1;
            ADC, SBB: w_c0 = cin;
            default:  w_c0 = 1'b0;
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] w_snx;

        addsub_seg #(.SEG(SEG)) u_seg (
            .a_seg    (w_a[k][k*SEG +: SEG]),
            .b_seg    (w_bx[k][k*SEG +: SEG]),
            .cin      (w_c[k]),
            .sum      (w_sum[k]),
            .cout     (w_co[k]),
            .cmsb     (w_cm[k]),
            .seg_zero (w_sz[k])
        );

        always_comb begin
            w_snx                 = w_s[k];
            w_snx[k*SEG +: SEG]   = w_sum[k];
        end
        assign w_s_nx[k] = w_snx;

        if (k == 0) begin : g_head
            assign w_a[k]  = a;
            assign w_bx[k] = w_b_eff;
            assign w_s[k]  = '0;
            assign w_c[k]  = w_c0;
            assign w_v[k]  = in_valid;
            assign w_z[k]  = 1'b1;
        end else begin : g_skew
            // Skew/deskew: upper operand bits and finished lower sum bits travel together.
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_bx;
            logic [WIDTH-1:0] r_s;
            logic             r_c;
            logic             r_v;
            logic             r_z;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a  <= '0;
                    r_bx <= '0;
                    r_s  <= '0;
                    r_c  <= 1'b0;
                    r_v  <= 1'b0;
                    r_z  <= 1'b0;
                end else if (!w_stall) begin
                    r_a  <= w_a[k-1];
                    r_bx <= w_bx[k-1];
                    r_s  <= w_s_nx[k-1];
                    r_c  <= w_co[k-1];
                    r_v  <= w_v[k-1];
                    r_z  <= w_z[k-1] & w_sz[k-1];
                end
            end

            assign w_a[k]  = r_a;
            assign w_bx[k] = r_bx;
            assign w_s[k]  = r_s;
            assign w_c[k]  = r_c;
            assign w_v[k]  = r_v;
            assign w_z[k]  = r_z;
        end
    end

    assign w_res_raw  = w_s_nx[STAGES-1];
    assign w_ovfl_fin = w_cm[STAGES-1] ^ w_co[STAGES-1];
    assign w_zero_acc = w_z[STAGES-1] & w_sz[STAGES-1];

`ifdef ADDSUB_PIPE_SAT_EN
    localparam logic [C_MAX_WIDTH-1:0] C_LIM_MAX = signed_limit(WIDTH, 1'b0);
    localparam logic [C_MAX_WIDTH-1:0] C_LIM_MIN = signed_limit(WIDTH, 1'b1);
    localparam logic [WIDTH-1:0]       C_SMAX    = C_LIM_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0]       C_SMIN    = C_LIM_MIN[WIDTH-1:0];

    // Overflow direction follows the sign of A; a saturated value is never zero.
    assign w_res_fin  = w_ovfl_fin ? (w_a[STAGES-1][WIDTH-1] ? C_SMIN : C_SMAX) : w_res_raw;
    assign w_zero_fin = w_zero_acc & ~w_ovfl_fin;
`else
    assign w_res_fin  = w_res_raw;
    assign w_zero_fin = w_zero_acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vout   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (!w_stall) begin
            r_vout       <= w_v[STAGES-1];
            r_result     <= w_res_fin;
            r_flags.cout <= w_co[STAGES-1];
            r_flags.ovfl <= w_ovfl_fin;
            r_flags.zero <= w_zero_fin;
            r_flags.neg  <= w_res_fin[WIDTH-1];
        end
    end

    assign out_valid = r_vout;
    assign result    = r_result;
    assign cout      = r_flags.cout;
    assign ovfl      = r_flags.ovfl;
    assign zero      = r_flags.zero;
    assign neg       = r_flags.neg;

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_pipe
//  Description : Scoreboard bench for addsub_pipe with an arithmetic reference
//                model (honours ADDSUB_PIPE_SAT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_pipe;

    localparam int     WIDTH  = 16;
    localparam int     SEG    = 4;
    localparam int     STAGES = WIDTH / SEG;
    localparam longint MOD    = longint'(1) << WIDTH;
    localparam longint MASK   = MOD - 1;
    localparam longint HALF   = MOD / 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [1:0]       op = 2'b00;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovfl;
    logic             zero;
    logic             neg;

    addsub_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovfl      (ovfl),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             ovfl;
        logic             zero;
        logic             neg;
        int               cyc;
        int               stalls;
    } exp_t;

    exp_t             sb[$];
    int               checks    = 0;
    int               failures  = 0;
    int               cyc       = 0;
    int               stall_cnt = 0;
    bit               held      = 1'b0;
    logic [WIDTH-1:0] h_res;
    logic [3:0]       h_flg;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow from the true result's range.
    function automatic exp_t model(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y, input logic ci);
        exp_t   e;
        longint ux, uy, sx, sy, raw, tru, r;
        longint c;
        bit     sub;
        ux  = longint'(x);
        uy  = longint'(y);
        sub = (o == 2'b01) || (o == 2'b11);
        c   = (o == 2'b00) ? 0 : (o == 2'b01) ? 1 : longint'(ci);
        raw = sub ? (ux + (MASK - uy) + c) : (ux + uy + c);
        r   = raw % MOD;
        sx  = (ux >= HALF) ? ux - MOD : ux;
        sy  = (uy >= HALF) ? uy - MOD : uy;
        tru = sub ? (sx - sy - (1 - c)) : (sx + sy + c);
        e.ovfl = (tru >= HALF) || (tru < -HALF);
        e.cout = (raw >= MOD);
`ifdef ADDSUB_PIPE_SAT_EN
        if (e.ovfl) r = (sx < 0) ? HALF : HALF - 1;
`endif
        e.res    = r[WIDTH-1:0];
        e.zero   = (r == 0);
        e.neg    = (r >= HALF);
        e.cyc    = 0;
        e.stalls = 0;
        return e;
    endfunction

    // Monitor, stall accounting and acceptance capture, all sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            check(in_ready == !(out_valid && !out_ready), "in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
            if (out_valid) begin
                if (held) begin
                    check(result == h_res, "hold_result", result, h_res);
                    check({cout, ovfl, zero, neg} == h_flg, "hold_flags", {cout, ovfl, zero, neg}, h_flg);
                end else if (sb.size() == 0) begin
                    check(1'b0 == out_valid, "unexpected_output", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check(result == e.res,  "result", result, e.res);
                    check(cout   == e.cout, "cout",   cout,   e.cout);
                    check(ovfl   == e.ovfl, "ovfl",   ovfl,   e.ovfl);
                    check(zero   == e.zero, "zero",   zero,   e.zero);
                    check(neg    == e.neg,  "neg",    neg,    e.neg);
                    if (e.stalls == stall_cnt)
                        check(cyc - e.cyc == STAGES, "latency", cyc - e.cyc, STAGES);
                end
                if (!out_ready) begin
                    held  = 1'b1;
                    h_res = result;
                    h_flg = {cout, ovfl, zero, neg};
                    stall_cnt++;
                end else begin
                    held = 1'b0;
                end
            end
            if (in_valid && in_ready) begin
                e        = model(op, a, b, cin);
                e.cyc    = cyc;
                e.stalls = stall_cnt;
                sb.push_back(e);
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic ci);
        int n = 0;
        in_valid = 1'b1;
        op = o; a = x; b = y; cin = ci;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check(in_ready == 1'b1, "accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [WIDTH-1:0] pick [5];
        pick[0] = '0; pick[1] = '1; pick[2] = 16'h7FFF; pick[3] = 16'h8000; pick[4] = 16'h0001;
        if ($urandom_range(3) == 0) return pick[$urandom_range(4)];
        return WIDTH'($urandom);
    endfunction

    task automatic rand_send();
        send(2'($urandom_range(3)), rnd_word(), rnd_word(), 1'($urandom_range(1)));
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(sb.size() == 0, "drain_empty", sb.size(), 0);
    endtask

    initial begin
        int  t0;
        bit  done;

        #1 rst = 1'b1;
        #1;
        check(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
        check(in_ready  == 1'b0, "reset_in_ready",  in_ready,  0);
        check(result    == '0,   "reset_result",    result,    0);
        check({cout, ovfl, zero, neg} == 4'b0, "reset_flags", {cout, ovfl, zero, neg}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // Directed boundary cases, each isolated.
        send(2'b00, 16'h7FFF, 16'h0001, 1'b0); idle(STAGES + 2);
        send(2'b01, 16'h0005, 16'h0005, 1'b0); idle(STAGES + 2);
        send(2'b01, 16'h8000, 16'h0001, 1'b0); idle(STAGES + 2);
        send(2'b10, 16'hFFFF, 16'h0000, 1'b1); idle(STAGES + 2);
        send(2'b11, 16'h0000, 16'h0000, 1'b0); idle(STAGES + 2);
        send(2'b00, 16'hFFFF, 16'h0001, 1'b1); idle(STAGES + 2);
        send(2'b01, 16'h0000, 16'h0001, 1'b0); idle(STAGES + 2);
        send(2'b11, 16'h0000, 16'h0000, 1'b1); idle(STAGES + 2);

        // Eight back-to-back beats with a three-cycle downstream stall.
        fork
            begin
                for (int i = 0; i < 8; i++) rand_send();
                in_valid = 1'b0;
            end
            begin
                repeat (6) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        drain();

        // Full-rate streaming: one accept per cycle.
        t0 = cyc;
        for (int i = 0; i < 20; i++) rand_send();
        check(cyc - t0 == 20, "throughput_cycles", cyc - t0, 20);
        drain();

        // Random gaps with random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(2) == 0) idle(1);
                    rand_send();
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with beats in flight.
        for (int i = 0; i < 3; i++) rand_send();
        idle(STAGES - 3);
        check(out_valid == 1'b1, "pre_reset_valid", out_valid, 1);
        #3 rst = 1'b1;
        #1;
        check(out_valid == 1'b0, "async_rst_valid", out_valid, 0);
        check(in_ready  == 1'b0, "async_rst_ready", in_ready,  0);
        check(result    == '0,   "async_rst_result", result,   0);
        check({cout, ovfl, zero, neg} == 4'b0, "async_rst_flags", {cout, ovfl, zero, neg}, 0);
        sb.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        idle(STAGES + 3);
        send(2'b00, 16'h1234, 16'h4321, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
